vga_hvsync_gen: RTL and testbench

//  Generates the VGA 640x480@60 timing (h/v sync, pixel coordinates, display-enable) from one

---
 rtl/vga_hvsync_gen.sv | 110 +++++++++++
 tb/tb_vga_hvsync_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_hvsync_gen.sv
// VGA 640x480@60 timing generator: pixel/line counters plus registered sync and display-enable flags.
// Optional HVSYNC_FRAME_PULSE_EN macro adds a one-clock frame_start pulse at (0,0).
`timescale 1ns/1ps
module vga_hvsync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       inDisplayArea,
   output logic [9:0] CounterX,
   output logic [9:0] CounterY
`ifdef HVSYNC_FRAME_PULSE_EN
   ,
   output logic       frame_start
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Boundaries are 11 bits so a sync window ending exactly at 1024 still compares correctly.
   localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_totals
         $error("vga_hvsync_gen: line/frame totals must lie in 1..1024");
      end
   endgenerate

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       de_q, de_d;
   logic       x_wrap;
   logic [10:0] x_ext, y_ext;

   // Flags are derived from the next counter values so they line up with the registered counters.
   always_comb begin
      x_wrap = (x_q >= H_LAST);
      x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
      y_d    = y_q;
      if (x_wrap) begin
         y_d = (y_q >= V_LAST) ? 10'd0 : y_q + 10'd1;
      end
      x_ext = {1'b0, x_d};
      y_ext = {1'b0, y_d};
      hs_d  = !((x_ext >= H_SYNC_START) && (x_ext < H_SYNC_END));
      vs_d  = !((y_ext >= V_SYNC_START) && (y_ext < V_SYNC_END));
      de_d  = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q  <= 10'd0;
         y_q  <= 10'd0;
         hs_q <= 1'b1;
         vs_q <= 1'b1;
         de_q <= 1'b0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
      end
   end

   assign CounterX      = x_q;
   assign CounterY      = y_q;
   assign vga_h_sync    = hs_q;
   assign vga_v_sync    = vs_q;
   assign inDisplayArea = de_q;

`ifdef HVSYNC_FRAME_PULSE_EN
   logic fs_q, fs_d;

   always_comb begin
      fs_d = (x_d == 10'd0) && (y_d == 10'd0);
   end

   // Reset forces 0 and the first counted edge moves to X=1, so no pulse right after release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fs_q <= 1'b0;
      end else begin
         fs_q <= fs_d;
      end
   end

   assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Scoreboard bench: full-size instance for line timing and reset, reduced-size instance for frame timing.
`timescale 1ns/1ps
module tb_vga_hvsync_gen;

   typedef struct {
      int         cnt;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic       a_hs, a_vs, a_de, a_fs;
   logic       b_hs, b_vs, b_de, b_fs;
   logic [9:0] a_x, a_y, b_x, b_y;

   vga_hvsync_gen dut_a (
      .clk           (clk),
      .reset         (rst_a),
      .vga_h_sync    (a_hs),
      .vga_v_sync    (a_vs),
      .inDisplayArea (a_de),
      .CounterX      (a_x),
      .CounterY      (a_y)
`ifdef HVSYNC_FRAME_PULSE_EN
      ,
      .frame_start   (a_fs)
`endif
   );

   vga_hvsync_gen #(
      .H_VISIBLE (64), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
      .V_VISIBLE (48), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
   ) dut_b (
      .clk           (clk),
      .reset         (rst_b),
      .vga_h_sync    (b_hs),
      .vga_v_sync    (b_vs),
      .inDisplayArea (b_de),
      .CounterX      (b_x),
      .CounterY      (b_y)
`ifdef HVSYNC_FRAME_PULSE_EN
      ,
      .frame_start   (b_fs)
`endif
   );

`ifndef HVSYNC_FRAME_PULSE_EN
   assign a_fs = 1'b0;
   assign b_fs = 1'b0;
`endif

   localparam int B_FRAME = 80 * 55;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   exp_t dir_a[12];
   exp_t dir_b[16];
   int   cnt_a = 0, cnt_b = 0;
   int   n_checks = 0, n_errors = 0, n_print = 0;
   int   hs_pulses = 0, vs_pulses = 0, de_cycles = 0, fs_pulses = 0;
   logic prev_hs_b = 1'b1, prev_vs_b = 1'b1;

   // Reference timing from elapsed edges since reset, using the raw range rules.
   function automatic exp_t model(input int cnt, input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
      exp_t e;
      int ht, vt, x, y;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      x = cnt % ht;
      y = (cnt / ht) % vt;
      e.cnt = cnt;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
      e.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
      e.de  = (cnt != 0) && (x < hv) && (y < vv);
      e.fs  = (cnt != 0) && (x == 0) && (y == 0);
      return e;
   endfunction

   function automatic exp_t mk(input int cnt, input int x, input int y, input logic hs, input logic vs,
                               input logic de, input logic fs);
      exp_t e;
      e.cnt = cnt; e.x = 10'(x); e.y = 10'(y);
      e.hs = hs; e.vs = vs; e.de = de; e.fs = fs;
      return e;
   endfunction

   task automatic check_sample(input string tag, input exp_t e, input logic [9:0] ax, input logic [9:0] ay,
                               input logic ahs, input logic avs, input logic ade, input logic afs);
      logic bad;
      n_checks++;
      bad = (ax !== e.x) || (ay !== e.y) || (ahs !== e.hs) || (avs !== e.vs) || (ade !== e.de);
`ifdef HVSYNC_FRAME_PULSE_EN
      bad = bad || (afs !== e.fs);
`endif
      if (bad) begin
         n_errors++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s cnt=%0d: got X=%0d Y=%0d hs=%b vs=%b de=%b fs=%b, expected X=%0d Y=%0d hs=%b vs=%b de=%b fs=%b",
                     tag, e.cnt, ax, ay, ahs, avs, ade, afs, e.x, e.y, e.hs, e.vs, e.de, e.fs);
         end
      end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end else begin
         $display("count %s = %0d", tag, got);
      end
   endtask

   task automatic step_a(input logic r, input int n);
      repeat (n) begin
         rst_a = r;
         @(posedge clk);
         #1;
         cnt_a = r ? cnt_a + 1 : 0;
         q_a.push_back(model(cnt_a, 640, 16, 96, 48, 480, 10, 2, 33));
      end
   endtask

   task automatic step_b(input logic r, input int n);
      repeat (n) begin
         rst_b = r;
         @(posedge clk);
         #1;
         cnt_b = r ? cnt_b + 1 : 0;
         q_b.push_back(model(cnt_b, 64, 4, 8, 4, 48, 2, 2, 3));
      end
   endtask

   // Monitor: pops one expected record per instance each cycle and compares at the falling edge.
   always @(negedge clk) begin
      if (q_a.size() > 0) begin
         e_a = q_a.pop_front();
         check_sample("A", e_a, a_x, a_y, a_hs, a_vs, a_de, a_fs);
         foreach (dir_a[k]) begin
            if (dir_a[k].cnt == e_a.cnt) begin
               check_sample("A_dir", dir_a[k], a_x, a_y, a_hs, a_vs, a_de, a_fs);
               $display("A cnt=%0d X=%0d Y=%0d hs=%b vs=%b de=%b", e_a.cnt, a_x, a_y, a_hs, a_vs, a_de);
            end
         end
      end
      if (q_b.size() > 0) begin
         e_b = q_b.pop_front();
         check_sample("B", e_b, b_x, b_y, b_hs, b_vs, b_de, b_fs);
         foreach (dir_b[k]) begin
            if (dir_b[k].cnt == e_b.cnt) begin
               check_sample("B_dir", dir_b[k], b_x, b_y, b_hs, b_vs, b_de, b_fs);
               $display("B cnt=%0d X=%0d Y=%0d hs=%b vs=%b de=%b fs=%b", e_b.cnt, b_x, b_y, b_hs, b_vs, b_de, b_fs);
            end
         end
         if (e_b.cnt >= 1 && e_b.cnt <= 3 * B_FRAME) begin
            if (!b_hs && prev_hs_b) hs_pulses++;
            if (!b_vs && prev_vs_b) vs_pulses++;
            if (b_de) de_cycles++;
            if (b_fs) fs_pulses++;
         end
         prev_hs_b = b_hs;
         prev_vs_b = b_vs;
         if (e_b.cnt == 3 * B_FRAME) begin
            check_count("hs_pulses_3frames", hs_pulses, 165);
            check_count("vs_pulses_3frames", vs_pulses, 3);
            check_count("de_cycles_3frames", de_cycles, 9216);
`ifdef HVSYNC_FRAME_PULSE_EN
            check_count("fs_pulses_3frames", fs_pulses, 3);
`endif
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Full-size timing, hand-computed: h sync 656..751, display X<640.
      dir_a[0]  = mk(0,    0,   0, 1, 1, 0, 0);
      dir_a[1]  = mk(1,    1,   0, 1, 1, 1, 0);
      dir_a[2]  = mk(639,  639, 0, 1, 1, 1, 0);
      dir_a[3]  = mk(640,  640, 0, 1, 1, 0, 0);
      dir_a[4]  = mk(655,  655, 0, 1, 1, 0, 0);
      dir_a[5]  = mk(656,  656, 0, 0, 1, 0, 0);
      dir_a[6]  = mk(751,  751, 0, 0, 1, 0, 0);
      dir_a[7]  = mk(752,  752, 0, 1, 1, 0, 0);
      dir_a[8]  = mk(799,  799, 0, 1, 1, 0, 0);
      dir_a[9]  = mk(800,  0,   1, 1, 1, 1, 0);
      dir_a[10] = mk(1456, 656, 1, 0, 1, 0, 0);
      dir_a[11] = mk(1900, 300, 2, 1, 1, 1, 0);
      // Reduced timing: 80 clks/line (h sync 68..75, display X<64), 55 lines (v sync 50..51).
      dir_b[0]  = mk(63,   63, 0,  1, 1, 1, 0);
      dir_b[1]  = mk(64,   64, 0,  1, 1, 0, 0);
      dir_b[2]  = mk(67,   67, 0,  1, 1, 0, 0);
      dir_b[3]  = mk(68,   68, 0,  0, 1, 0, 0);
      dir_b[4]  = mk(75,   75, 0,  0, 1, 0, 0);
      dir_b[5]  = mk(76,   76, 0,  1, 1, 0, 0);
      dir_b[6]  = mk(3839, 79, 47, 1, 1, 0, 0);
      dir_b[7]  = mk(3840, 0,  48, 1, 1, 0, 0);
      dir_b[8]  = mk(3999, 79, 49, 1, 1, 0, 0);
      dir_b[9]  = mk(4000, 0,  50, 1, 0, 0, 0);
      dir_b[10] = mk(4068, 68, 50, 0, 0, 0, 0);
      dir_b[11] = mk(4159, 79, 51, 1, 0, 0, 0);
      dir_b[12] = mk(4160, 0,  52, 1, 1, 0, 0);
      dir_b[13] = mk(4399, 79, 54, 1, 1, 0, 0);
      dir_b[14] = mk(4400, 0,  0,  1, 1, 1, 1);
      dir_b[15] = mk(4401, 1,  0,  1, 1, 1, 0);

      rst_a = 1'b0;
      rst_b = 1'b0;
      fork
         begin
            step_a(1'b0, 5);
            step_a(1'b1, 1900);   // ends at X=300, Y=2
            step_a(1'b0, 1);      // mid-frame reset
            step_a(1'b0, 2);
            step_a(1'b1, 900);
         end
         begin
            step_b(1'b0, 5);
            step_b(1'b1, 3 * B_FRAME + 5);
         end
      join
      repeat (2) @(negedge clk);
      check_count("queue_drain", q_a.size() + q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
